// File: rtl/countdown_sequencer.sv
// Countdown sequencer: presettable 4-bit down counter with run/pause/stop control
// and a prescaler that turns TICK_DIV clock cycles into one count tick.
module countdown_sequencer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk_50M,
  input  logic       Reset,
  input  logic       Load,
  input  logic [3:0] Preset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Stop,
  output logic [3:0] Count,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] State
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    preset_q, preset_d;
  logic [PW-1:0] presc_q, presc_d;

  // State and datapath registers
  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      count_q  <= 4'd0;
      preset_q <= 4'd0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      preset_q <= preset_d;
      presc_q  <= presc_d;
    end
  end

  // Next-state logic; command priority is Stop > Pause > Start > Load
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    preset_d = preset_q;
    presc_d  = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (Stop) begin
          presc_d = '0;
        end else if (Start) begin
          if (preset_q != 4'd0) begin
            count_d = preset_q;
            presc_d = '0;
            state_d = ST_RUN;
          end else begin
            count_d = 4'd0;
            state_d = ST_DONE;
          end
        end else if (Load) begin
          preset_d = Preset;
          count_d  = Preset;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (Pause) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_MAX) begin
          // Tick: the last step goes to zero and terminates, never wrapping
          presc_d = '0;
          if (count_q > 4'd1) begin
            count_d = count_q - 4'd1;
          end else begin
            count_d = 4'd0;
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_PAUSE: begin
        if (Stop) begin
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (Start && !Pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        presc_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Count = count_q;
  assign State = state_q;
  assign Busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign Done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios with literal expectations plus
// randomized commands checked every cycle against a behavioural model.
module tb_countdown_sequencer;

  localparam int unsigned TD = 4;

  logic       clk_50M = 1'b0;
  logic       Reset   = 1'b0;
  logic       Load    = 1'b0;
  logic [3:0] Preset  = 4'd0;
  logic       Start   = 1'b0;
  logic       Pause   = 1'b0;
  logic       Stop    = 1'b0;
  logic [3:0] Count;
  logic       Busy;
  logic       Done;
  logic [1:0] State;

  countdown_sequencer #(.TICK_DIV(TD)) dut (
    .clk_50M(clk_50M),
    .Reset  (Reset),
    .Load   (Load),
    .Preset (Preset),
    .Start  (Start),
    .Pause  (Pause),
    .Stop   (Stop),
    .Count  (Count),
    .Busy   (Busy),
    .Done   (Done),
    .State  (State)
  );

  always #5 clk_50M = ~clk_50M;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode uses the output encoding 0=idle 1=run 2=pause 3=done;
  // elapsed counts run cycles since the last tick.
  int m_mode    = 0;
  int m_count   = 0;
  int m_preset  = 0;
  int m_elapsed = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!Reset) begin
      m_mode = 0; m_count = 0; m_preset = 0; m_elapsed = 0;
    end else if (Stop) begin
      m_mode = 0; m_elapsed = 0;
    end else begin
      case (m_mode)
        0: begin
          if (Start) begin
            m_elapsed = 0;
            if (m_preset == 0) begin m_count = 0; m_mode = 3; end
            else begin m_count = m_preset; m_mode = 1; end
          end else if (Load) begin
            m_preset = int'(Preset);
            m_count  = int'(Preset);
          end
        end
        1: begin
          if (Pause) m_mode = 2;
          else begin
            m_elapsed = (m_elapsed + 1) % TD;
            if (m_elapsed == 0) begin
              m_count = m_count - 1;
              if (m_count == 0) m_mode = 3;
            end
          end
        end
        2: if (Start && !Pause) m_mode = 1;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic compare();
    chk("count", int'(Count), m_count);
    chk("state", int'(State), m_mode);
    chk("busy",  int'(Busy),  (m_mode == 1 || m_mode == 2) ? 1 : 0);
    chk("done",  int'(Done),  (m_mode == 3) ? 1 : 0);
  endtask

  task automatic step();
    @(posedge clk_50M);
    model_update();
    #1;
    compare();
  endtask

  task automatic clear_cmds();
    Load = 0; Start = 0; Pause = 0; Stop = 0;
  endtask

  initial begin
    // Reset state before any clock edge
    #2;
    chk("rst_count", int'(Count), 0);
    chk("rst_state", int'(State), 0);
    chk("rst_busy",  int'(Busy),  0);
    chk("rst_done",  int'(Done),  0);
    step();
    Reset = 1;
    step();

    // Preset 3: 3,2,1,0 at four-cycle spacing, then DONE for one cycle
    Load = 1; Preset = 4'd3;
    step();
    chk("load3_count", int'(Count), 3);
    Load = 0; Start = 1;
    step();
    chk("start_state", int'(State), 1);
    Start = 0;
    repeat (3) step();
    chk("pre_tick_count", int'(Count), 3);
    step();
    chk("first_tick_count", int'(Count), 2);
    repeat (4) step();
    chk("second_tick_count", int'(Count), 1);
    repeat (3) step();
    chk("pre_done_state", int'(State), 1);
    step();
    chk("done_state", int'(State), 3);
    chk("done_pulse", int'(Done), 1);
    chk("done_count", int'(Count), 0);
    step();
    chk("after_done_state", int'(State), 0);
    chk("after_done_pulse", int'(Done), 0);

    // Preset 0: straight to DONE, never busy
    Load = 1; Preset = 4'd0;
    step();
    Load = 0; Start = 1;
    step();
    chk("zero_done_state", int'(State), 3);
    chk("zero_busy", int'(Busy), 0);
    Start = 0;
    step();
    chk("zero_idle_state", int'(State), 0);

    // Preset 5: pause at prescaler 2, resume, decrement two cycles later
    Load = 1; Preset = 4'd5;
    step();
    Load = 0; Start = 1;
    step();
    Start = 0;
    repeat (2) step();
    Pause = 1;
    repeat (10) step();
    chk("paused_state", int'(State), 2);
    chk("paused_count", int'(Count), 5);
    chk("paused_busy",  int'(Busy), 1);
    Pause = 0; Start = 1;
    step();
    chk("resume_state", int'(State), 1);
    Start = 0;
    step();
    chk("resume_hold_count", int'(Count), 5);
    step();
    chk("resume_tick_count", int'(Count), 4);

    // Start, Pause and Stop together in RUN: Stop wins
    Start = 1; Pause = 1; Stop = 1;
    step();
    chk("stop_state", int'(State), 0);
    chk("stop_count", int'(Count), 4);
    chk("stop_done",  int'(Done), 0);
    clear_cmds();
    step();

    // Asynchronous reset between edges while running with Count=4
    Load = 1; Preset = 4'd4;
    step();
    Load = 0; Start = 1;
    step();
    Start = 0;
    step();
    #3 Reset = 0;
    #1;
    chk("async_count", int'(Count), 0);
    chk("async_state", int'(State), 0);
    chk("async_busy",  int'(Busy), 0);
    step();
    Reset = 1;
    step();

    // Load during RUN ignored; accepted once back in IDLE
    Load = 1; Preset = 4'd2;
    step();
    Load = 0; Start = 1;
    step();
    Start = 0; Load = 1; Preset = 4'd9;
    repeat (7) step();
    chk("run_load_ignored", int'(Count), 1);
    step();
    chk("run_load_done", int'(State), 3);
    step();
    chk("idle_load_pending", int'(Count), 0);
    step();
    chk("idle_load_count", int'(Count), 9);
    clear_cmds();
    step();

    // Randomized command mix
    for (int i = 0; i < 4000; i++) begin
      Reset  = ($urandom_range(0, 999) < 5) ? 1'b0 : 1'b1;
      Stop   = ($urandom_range(0, 99) < 3);
      Pause  = ($urandom_range(0, 99) < 8);
      Start  = ($urandom_range(0, 99) < 15);
      Load   = ($urandom_range(0, 99) < 15);
      Preset = 4'($urandom_range(0, 15));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
